sap_run_ctrl: RTL and testbench

//  Run/halt/single-step controller sitting directly upstream of the clock-gating stage.
//  - Runs on the free-running board clock.
//  - Merges the CPU's HLT-instruction decode with three debounced front-panel buttons (run, step, halt).
//  - Produces the registered hlt level that gates the CPU clock.
//  - Also produces status flags for LEDs and the debug interface.

---
 rtl/sap_run_ctrl.sv | 157 +++++++++++++++
 tb/tb_sap_run_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sap_run_ctrl.sv
// Run/halt/single-step controller feeding the CPU clock gate.
// Merges HLT decode with debounced run/step/halt buttons.
module sap_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STEP_CYCLES     = 1,
  parameter bit START_HALTED    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hlt_instr,
  input  logic       run_btn,
  input  logic       step_btn,
  input  logic       halt_btn,
  output logic       hlt,
  output logic       running,
  output logic       stepping,
  output logic [1:0] halt_cause
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW =
    (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] STEP_LAST =
    SW'(STEP_CYCLES - 1);

  localparam logic [1:0] CAUSE_RST   = 2'b00;
  localparam logic [1:0] CAUSE_INSTR = 2'b01;
  localparam logic [1:0] CAUSE_BTN   = 2'b10;
  localparam logic [1:0] CAUSE_DONE  = 2'b11;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    STEP   = 2'd2
  } state_t;

  localparam state_t RST_STATE =
    START_HALTED ? HALTED : RUN;

  // Bit order for all button vectors: {halt, step, run}
  logic [2:0]    btn_raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    stable;
  logic [2:0]    stable_q;
  logic [2:0]    press;
  logic [CW-1:0] db_cnt [3];

  logic          hlt_instr_q;
  logic          hlt_ev;
  logic          run_p;
  logic          step_p;
  logic          halt_p;

  state_t        state;
  logic [SW-1:0] step_cnt;

  assign btn_raw = {halt_btn, step_btn, run_btn};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_q <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      stable_q <= stable;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign press  = stable & ~stable_q;
  assign run_p  = press[0];
  assign step_p = press[1];
  assign halt_p = press[2];

  // Edge only: a held HLT must not re-halt after resume
  assign hlt_ev = hlt_instr & ~hlt_instr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RST_STATE;
      hlt         <= START_HALTED;
      running     <= ~START_HALTED;
      stepping    <= 1'b0;
      halt_cause  <= CAUSE_RST;
      step_cnt    <= '0;
      hlt_instr_q <= 1'b0;
    end else begin
      hlt_instr_q <= hlt_instr;
      case (state)
        RUN: begin
          if (halt_p || hlt_ev) begin
            state      <= HALTED;
            hlt        <= 1'b1;
            running    <= 1'b0;
            halt_cause <= halt_p ? CAUSE_BTN
                                 : CAUSE_INSTR;
          end
        end
        HALTED: begin
          if (step_p) begin
            state    <= STEP;
            hlt      <= 1'b0;
            stepping <= 1'b1;
            step_cnt <= '0;
          end else if (run_p) begin
            state   <= RUN;
            hlt     <= 1'b0;
            running <= 1'b1;
          end
        end
        STEP: begin
          if (halt_p || hlt_ev ||
              step_cnt == STEP_LAST) begin
            state    <= HALTED;
            hlt      <= 1'b1;
            stepping <= 1'b0;
            if (halt_p) begin
              halt_cause <= CAUSE_BTN;
            end else if (hlt_ev) begin
              halt_cause <= CAUSE_INSTR;
            end else begin
              halt_cause <= CAUSE_DONE;
            end
          end else begin
            step_cnt <= step_cnt + SW'(1);
          end
        end
        default: begin
          state    <= RST_STATE;
          hlt      <= START_HALTED;
          running  <= ~START_HALTED;
          stepping <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sap_run_ctrl.sv
// Directed bench for sap_run_ctrl: vector table plus
// hand-written multi-cycle sequences on two parameter sets.
module tb_sap_run_ctrl;

  localparam logic [2:0] B_RUN  = 3'b001;
  localparam logic [2:0] B_STEP = 3'b010;
  localparam logic [2:0] B_HALT = 3'b100;

  logic       clk;
  logic       rst;
  logic       hlt_instr;
  logic       run_btn;
  logic       step_btn;
  logic       halt_btn;
  logic       hlt;
  logic       running;
  logic       stepping;
  logic [1:0] halt_cause;
  logic       hlt1;
  logic       running1;
  logic       stepping1;
  logic [1:0] cause1;

  int n_chk;
  int n_fail;

  logic hist  [0:63];
  logic hist1 [0:63];

  typedef struct {
    logic [2:0] btns;
    int         hold;
    int         ia;
    int         il;
    logic       e_hlt;
    logic       e_run;
    logic       e_step;
    logic [1:0] e_cause;
  } vec_t;

  vec_t tbl [12];

  sap_run_ctrl #(
    .DEBOUNCE_CYCLES(16),
    .STEP_CYCLES(4),
    .START_HALTED(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hlt_instr(hlt_instr),
    .run_btn(run_btn),
    .step_btn(step_btn),
    .halt_btn(halt_btn),
    .hlt(hlt),
    .running(running),
    .stepping(stepping),
    .halt_cause(halt_cause)
  );

  sap_run_ctrl dut1 (
    .clk(clk),
    .rst(rst),
    .hlt_instr(hlt_instr),
    .run_btn(run_btn),
    .step_btn(step_btn),
    .halt_btn(halt_btn),
    .hlt(hlt1),
    .running(running1),
    .stepping(stepping1),
    .halt_cause(cause1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, got, exp);
    end
  endtask

  // Index i = negedge following the i-th posedge
  // after the buttons are driven.
  task automatic run_trace(input logic [2:0] b,
                           input int hold,
                           input int ia,
                           input int il,
                           input int n);
    {halt_btn, step_btn, run_btn} = b;
    hist[0]  = hlt;
    hist1[0] = hlt1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      hist[i]  = hlt;
      hist1[i] = hlt1;
      if (i == hold) {halt_btn, step_btn, run_btn} = 3'b000;
      if (i == ia) hlt_instr = 1'b1;
      if (i == ia + il) hlt_instr = 1'b0;
    end
  endtask

  function automatic int lows(input bit w,
                              input int from,
                              input int to);
    int c;
    c = 0;
    for (int i = from; i <= to; i++) begin
      if ((w ? hist1[i] : hist[i]) === 1'b0) c++;
    end
    return c;
  endfunction

  function automatic int first_val(input bit w,
                                   input logic v,
                                   input int from,
                                   input int to);
    for (int i = from; i <= to; i++) begin
      if ((w ? hist1[i] : hist[i]) === v) return i;
    end
    return -1;
  endfunction

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    hlt_instr = 1'b0;
    {halt_btn, step_btn, run_btn} = 3'b000;

    tbl[0]  = '{3'b000, 1, 1, 3, 1'b1, 1'b0, 1'b0, 2'b01};
    tbl[1]  = '{B_RUN, 16, -1, 0, 1'b0, 1'b1, 1'b0, 2'b01};
    tbl[2]  = '{B_STEP, 16, -1, 0, 1'b0, 1'b1, 1'b0, 2'b01};
    tbl[3]  = '{B_RUN, 16, -1, 0, 1'b0, 1'b1, 1'b0, 2'b01};
    tbl[4]  = '{B_HALT, 16, -1, 0, 1'b1, 1'b0, 1'b0, 2'b10};
    tbl[5]  = '{B_STEP, 15, -1, 0, 1'b1, 1'b0, 1'b0, 2'b10};
    tbl[6]  = '{B_RUN, 15, -1, 0, 1'b1, 1'b0, 1'b0, 2'b10};
    tbl[7]  = '{B_STEP, 16, -1, 0, 1'b1, 1'b0, 1'b0, 2'b11};
    tbl[8]  = '{B_RUN, 16, -1, 0, 1'b0, 1'b1, 1'b0, 2'b11};
    tbl[9]  = '{B_HALT, 15, -1, 0, 1'b0, 1'b1, 1'b0, 2'b11};
    tbl[10] = '{B_HALT, 16, -1, 0, 1'b1, 1'b0, 1'b0, 2'b10};
    tbl[11] = '{B_RUN, 16, -1, 0, 1'b0, 1'b1, 1'b0, 2'b10};

    // Reset state, during and after reset
    repeat (3) @(negedge clk);
    chk("rst_hlt", 32'(hlt), 32'(0));
    chk("rst_running", 32'(running), 32'(1));
    chk("rst_stepping", 32'(stepping), 32'(0));
    chk("rst_cause", 32'(halt_cause), 32'(0));
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_hlt", 32'(hlt), 32'(0));
    chk("post_rst_running", 32'(running), 32'(1));
    chk("post_rst_cause", 32'(halt_cause), 32'(0));
    chk("post_rst_hlt1", 32'(hlt1), 32'(0));

    // HLT instruction halts one edge later, then step
    hlt_instr = 1'b1;
    @(negedge clk);
    chk("instr_hlt", 32'(hlt), 32'(1));
    chk("instr_cause", 32'(halt_cause), 32'(1));
    chk("instr_running", 32'(running), 32'(0));
    chk("instr_hlt1", 32'(hlt1), 32'(1));
    run_trace(B_STEP, 16, -1, 0, 50);
    chk("step_first_lo", 32'(first_val(0, 1'b0, 1, 50)),
        32'(19));
    chk("step_lows", 32'(lows(0, 1, 50)), 32'(4));
    chk("step_lows1", 32'(lows(1, 1, 50)), 32'(1));
    chk("step_cause", 32'(halt_cause), 32'(3));
    chk("step_cause1", 32'(cause1), 32'(3));
    chk("step_hlt", 32'(hlt), 32'(1));
    hlt_instr = 1'b0;
    repeat (3) @(negedge clk);

    // Debounce boundary: 15 rejected, 16 accepted
    run_trace(B_STEP, 15, -1, 0, 50);
    chk("glitch15_lows", 32'(lows(0, 1, 50)), 32'(0));
    chk("glitch15_lows1", 32'(lows(1, 1, 50)), 32'(0));
    run_trace(B_STEP, 16, -1, 0, 50);
    chk("press16_first_lo",
        32'(first_val(0, 1'b0, 1, 50)), 32'(19));
    chk("press16_lows", 32'(lows(0, 1, 50)), 32'(4));
    chk("press16_lows1", 32'(lows(1, 1, 50)), 32'(1));

    // Halt and step together while halted: step wins
    run_trace(B_HALT | B_STEP, 16, -1, 0, 50);
    chk("hs_first_lo", 32'(first_val(0, 1'b0, 1, 50)),
        32'(19));
    chk("hs_lows", 32'(lows(0, 1, 50)), 32'(4));
    chk("hs_lows1", 32'(lows(1, 1, 50)), 32'(1));
    chk("hs_cause", 32'(halt_cause), 32'(3));
    run_trace(B_RUN, 16, -1, 0, 40);
    chk("resume_running", 32'(running), 32'(1));

    // In RUN, halt pulse and HLT event on the same edge
    run_trace(B_HALT, 16, 18, 3, 45);
    chk("coin_first_hi", 32'(first_val(0, 1'b1, 1, 45)),
        32'(19));
    chk("coin_cause", 32'(halt_cause), 32'(2));
    chk("coin_cause1", 32'(cause1), 32'(2));
    run_trace(B_RUN, 16, -1, 0, 40);

    for (int r = 0; r < 12; r++) begin
      run_trace(tbl[r].btns, tbl[r].hold,
                tbl[r].ia, tbl[r].il, 45);
      chk($sformatf("row%0d_hlt", r),
          32'(hlt), 32'(tbl[r].e_hlt));
      chk($sformatf("row%0d_running", r),
          32'(running), 32'(tbl[r].e_run));
      chk($sformatf("row%0d_stepping", r),
          32'(stepping), 32'(tbl[r].e_step));
      chk($sformatf("row%0d_cause", r),
          32'(halt_cause), 32'(tbl[r].e_cause));
      chk($sformatf("row%0d_hlt1", r),
          32'(hlt1), 32'(tbl[r].e_hlt));
      chk($sformatf("row%0d_cause1", r),
          32'(cause1), 32'(tbl[r].e_cause));
    end

    // Async reset mid-step, button held through release
    hlt_instr = 1'b1;
    @(negedge clk);
    hlt_instr = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre6_hlt", 32'(hlt), 32'(1));
    run_trace(B_STEP, 100, -1, 0, 21);
    chk("mid_first_lo", 32'(first_val(0, 1'b0, 1, 21)),
        32'(19));
    chk("mid_stepping", 32'(stepping), 32'(1));
    chk("mid_cause1", 32'(cause1), 32'(3));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_hlt", 32'(hlt), 32'(0));
    chk("arst_running", 32'(running), 32'(1));
    chk("arst_stepping", 32'(stepping), 32'(0));
    chk("arst_cause", 32'(halt_cause), 32'(0));
    chk("arst_running1", 32'(running1), 32'(1));
    chk("arst_cause1", 32'(cause1), 32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_trace(B_STEP, 45, 1, 2, 60);
    chk("rel_instr_hlt", 32'(hist[2]), 32'(1));
    chk("rel_first_lo", 32'(first_val(0, 1'b0, 3, 60)),
        32'(19));
    chk("rel_lows", 32'(lows(0, 3, 60)), 32'(4));
    chk("rel_lows1", 32'(lows(1, 3, 60)), 32'(1));
    chk("rel_cause", 32'(halt_cause), 32'(3));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
